mul_pipe_param: RTL and testbench

- Parametrised, stall- and kill-aware RISC-V M-extension multiplier pipeline (MUL, MULH, MULHSU, MULHU).
- Successor to the fixed-depth multiplier: configurable width and depth, branch-kill flush, an in-flight destination query for the hazard unit, and an occupancy count.
- Sits beside the execute stage. It takes decoded operands from the DEC/EXE boundary and returns results to the MEM/WB merge point.

---
 rtl/mul_pipe_param.sv | 99 +++++++++
 tb/tb_mul_pipe_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe_param.sv
// RISC-V M-extension multiplier pipeline with configurable width and depth.
// Supports stall and kill, answers hazard queries on in-flight destinations, and reports occupancy.
module mul_pipe_param #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [1:0]                    in_op,
  input  logic [XLEN-1:0]               in_a,
  input  logic [XLEN-1:0]               in_b,
  input  logic [TAG_W-1:0]              in_rd,
  output logic                          in_ready,
  input  logic                          stall_in,
  input  logic                          kill_in,
  output logic                          out_valid,
  output logic [XLEN-1:0]               out_result,
  output logic [TAG_W-1:0]              out_rd,
  input  logic [TAG_W-1:0]              q_rs1,
  input  logic [TAG_W-1:0]              q_rs2,
  output logic                          q_hit1,
  output logic                          q_hit2,
  output logic [$clog2(STAGES+1)-1:0]   count,
  output logic                          busy
);

  localparam int CW = $clog2(STAGES+1);

  logic [STAGES-1:0] vld_q, vld_d;
  logic [XLEN-1:0]   res_q [STAGES];
  logic [TAG_W-1:0]  rd_q  [STAGES];
  logic [CW-1:0]     count_q, count_d;

  logic              sgn_a, sgn_b, accept, leave;
  logic [2*XLEN-1:0] a_w, b_w, prod;
  logic [XLEN-1:0]   res_d;

  // Sign-extending both operands straight to 2*XLEN and keeping only the low
  // 2*XLEN product bits equals the low bits of the full (XLEN+1)-bit signed product.
  always_comb begin
    sgn_a = (in_op == 2'd1) || (in_op == 2'd2);
    sgn_b = (in_op == 2'd1);
    a_w   = {{XLEN{sgn_a & in_a[XLEN-1]}}, in_a};
    b_w   = {{XLEN{sgn_b & in_b[XLEN-1]}}, in_b};
    prod  = a_w * b_w;
    res_d = (in_op == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    accept   = in_valid & ~stall_in & ~kill_in;
    leave    = vld_q[STAGES-1] & ~stall_in;
    vld_d    = vld_q;
    vld_d[0] = accept;
    for (int unsigned i = 1; i < STAGES; i++) vld_d[i] = vld_q[i-1];
    count_d  = kill_in ? '0 : count_q + CW'(accept) - CW'(leave);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        rd_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      if (kill_in)       vld_q <= '0;
      else if (!stall_in) vld_q <= vld_d;
      if (!stall_in) begin
        res_q[0] <= res_d;
        rd_q[0]  <= in_rd;
        for (int unsigned i = 1; i < STAGES; i++) begin
          res_q[i] <= res_q[i-1];
          rd_q[i]  <= rd_q[i-1];
        end
      end
    end
  end

  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      q_hit1 = q_hit1 | (vld_q[i] & (rd_q[i] == q_rs1) & (rd_q[i] != '0));
      q_hit2 = q_hit2 | (vld_q[i] & (rd_q[i] == q_rs2) & (rd_q[i] != '0));
    end
  end

  assign in_ready   = ~stall_in;
  assign out_valid  = vld_q[STAGES-1];
  assign out_result = res_q[STAGES-1];
  assign out_rd     = rd_q[STAGES-1];
  assign count      = count_q;
  assign busy       = (count_q != '0);

endmodule

// File: tb/tb_mul_pipe_param.sv
// Scoreboard bench for mul_pipe_param: the stimulus side queues expected results,
// and a negedge monitor compares outputs, occupancy and hazard hits against that queue.
module tb_mul_pipe_param;

  localparam int XLEN   = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [1:0]       in_op = '0;
  logic [XLEN-1:0]  in_a = '0, in_b = '0;
  logic [TAG_W-1:0] in_rd = '0;
  logic             in_ready;
  logic             stall_in = 1'b0, kill_in = 1'b0;
  logic             out_valid;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_rd;
  logic [TAG_W-1:0] q_rs1 = '0, q_rs2 = '0;
  logic             q_hit1, q_hit2;
  logic [1:0]       count;
  logic             busy;

  mul_pipe_param #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_rd(in_rd), .in_ready(in_ready), .stall_in(stall_in), .kill_in(kill_in),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: full-width signed product of (XLEN+1)-bit extended operands.
  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [XLEN:0]     ea, eb;
    logic signed [2*XLEN+1:0] p;
    ea = $signed({(op == 2'd1 || op == 2'd2) ? a[XLEN-1] : 1'b0, a});
    eb = $signed({(op == 2'd1) ? b[XLEN-1] : 1'b0, b});
    p  = ea * eb;
    return (op == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] rd;
    int               tag;
  } ent_t;

  ent_t sbq[$];
  int   adv = 0;   // number of unstalled, unkilled clock edges so far

  // Stimulus bookkeeping: every accepted op is queued with the advance count at acceptance.
  always @(posedge clk) begin
    if (rst) begin
      if (kill_in) sbq.delete();
      else if (!stall_in) begin
        adv++;
        if (in_valid) sbq.push_back('{ref_mul(in_op, in_a, in_b), in_rd, adv});
      end
    end
  end

  always @(negedge rst) sbq.delete();

  // Monitor: an op is visible STAGES-1 advances after acceptance; consumed when not stalled.
  always @(negedge clk) begin
    logic exp_v, h1, h2;
    if (!rst) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
    end else begin
      exp_v = (sbq.size() > 0) && (adv - sbq[0].tag == STAGES - 1);
      h1 = 1'b0;
      h2 = 1'b0;
      foreach (sbq[i]) begin
        if (sbq[i].rd != '0 && sbq[i].rd == q_rs1) h1 = 1'b1;
        if (sbq[i].rd != '0 && sbq[i].rd == q_rs2) h2 = 1'b1;
      end
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      if (exp_v && out_valid) begin
        chk("out_result", 64'(out_result), 64'(sbq[0].res));
        chk("out_rd", 64'(out_rd), 64'(sbq[0].rd));
      end
      chk("count", 64'(count), 64'(sbq.size()));
      chk("busy", 64'(busy), 64'(sbq.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(!stall_in));
      chk("q_hit1", 64'(q_hit1), 64'(h1));
      chk("q_hit2", 64'(q_hit2), 64'(h2));
      if (exp_v && !stall_in && !kill_in) void'(sbq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] rd);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_rd = rd;
  endtask

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [1:0]      d_op  [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  logic [XLEN-1:0] d_a   [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [XLEN-1:0] d_b   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [XLEN-1:0] d_exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

  initial begin
    step();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_result", 64'(out_result), 64'd0);
    rst = 1'b1;
    step();

    // Directed arithmetic with exact latency
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d_op[i], d_a[i], d_b[i], 5'd1);
      step();
      in_valid = 1'b0;
      step();
      chk("lat_early", 64'(out_valid), 64'd0);
      step();
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("dir_result", 64'(out_result), 64'(d_exp[i]));
      step();
      chk("lat_drop", 64'(out_valid), 64'd0);
    end

    // Stall: A, B accepted, C held for two stalled edges
    drive(1'b1, 2'd0, 32'd11, 32'd13, 5'd3); step();
    drive(1'b1, 2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd4); step();
    drive(1'b1, 2'd2, 32'hCAFE_F00D, 32'h8765_4321, 5'd6);
    stall_in = 1'b1;
    step();
    chk("stall_ready", 64'(in_ready), 64'd0);
    step();
    chk("stall_ready2", 64'(in_ready), 64'd0);
    stall_in = 1'b0;
    step();
    chk("stall_count_peak", 64'(count), 64'd3);
    in_valid = 1'b0;
    repeat (5) step();

    // Kill with stall asserted
    drive(1'b1, 2'd0, 32'd5, 32'd6, 5'd7); step();
    drive(1'b1, 2'd3, 32'd9, 32'd10, 5'd8); step();
    drive(1'b1, 2'd0, 32'd2, 32'd2, 5'd9);
    kill_in = 1'b1; stall_in = 1'b1;
    step();
    kill_in = 1'b0; stall_in = 1'b0; in_valid = 1'b0;
    chk("kill_count", 64'(count), 64'd0);
    chk("kill_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("kill_no_out", 64'(out_valid), 64'd0);
    end

    // Hazard query
    q_rs1 = 5'd5;
    drive(1'b1, 2'd0, 32'd3, 32'd3, 5'd5); step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("haz_hit", 64'(q_hit1), 64'd1);
      step();
    end
    chk("haz_gone", 64'(q_hit1), 64'd0);
    q_rs2 = 5'd0;
    drive(1'b1, 2'd0, 32'd4, 32'd4, 5'd0); step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("haz_rd0", 64'(q_hit2), 64'd0);
      step();
    end
    repeat (2) step();

    // Asynchronous reset mid-flight
    drive(1'b1, 2'd0, 32'd8, 32'd8, 5'd10); step();
    drive(1'b1, 2'd0, 32'd9, 32'd9, 5'd11); step();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("amid_out_valid", 64'(out_valid), 64'd0);
    chk("amid_count", 64'(count), 64'd0);
    chk("amid_busy", 64'(busy), 64'd0);
    #3 rst = 1'b1;
    drive(1'b1, 2'd0, 32'd3, 32'd4, 5'd2); step();
    in_valid = 1'b0;
    step(); step();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_result", 64'(out_result), 64'd12);
    repeat (2) step();

    // Throughput: 10 back-to-back MULs
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'd0, 32'(i + 1), 32'(i + 100), 5'(i + 1));
      step();
      if (i >= 2) chk("thr_valid", 64'(out_valid), 64'd1);
      if (i >= 2) chk("thr_count", 64'(count), 64'd3);
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Randomized traffic with stalls, kills and queries
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), pick(), pick(), 5'($urandom_range(0, 7)));
      stall_in = ($urandom_range(0, 3) == 0);
      kill_in  = ($urandom_range(0, 31) == 0);
      q_rs1 = 5'($urandom_range(0, 7));
      q_rs2 = 5'($urandom_range(0, 7));
      step();
    end
    drive(1'b0, 2'd0, '0, '0, '0);
    stall_in = 1'b0; kill_in = 1'b0;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
